// File: rtl/gate_resp_checker_if.sv
// Handshake and result bundle between a gate stimulus driver and gate_resp_checker.
// The master drives the applied vector and the DUT response; the slave (the checker)
// returns run status, counters and the first captured mismatch.
interface gate_resp_checker_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             vec_valid;
   logic             a;
   logic             b;
   logic             y;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [2:0]       first_fail;
   logic             first_fail_vld;
   logic             overrun;

   modport master (
      output start, vec_valid, a, b, y,
      input  busy, done, pass, vec_cnt, err_cnt, first_fail, first_fail_vld, overrun
   );

   modport slave (
      input  start, vec_valid, a, b, y,
      output busy, done, pass, vec_cnt, err_cnt, first_fail, first_fail_vld, overrun
   );
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for 2-input gate DUTs. Each vec_valid latches (a,b), waits SETTLE
// clocks, then compares y with the truth table of GATE_OP and updates the run counters.
// Optional feature macro GATE_CHK_STOP_ON_FAIL_EN: the first mismatch ends the run.
module gate_resp_checker #(
   parameter int GATE_OP     = 2,
   parameter int NUM_VECTORS = 4,
   parameter int SETTLE      = 1,
   parameter int CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   gate_resp_checker_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ARMED, SETTLE_WAIT, DONE} state_t;

   localparam int               SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] VEC_LAST    = CNT_W'(NUM_VECTORS);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   state_t           state_q, state_d;
   logic             a_q, a_d, b_q, b_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [2:0]       ff_q, ff_d;
   logic             ffv_q, ffv_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             exp_y;
   logic             mismatch;

   // Expected gate output for the latched vector.
   always_comb begin
      case (GATE_OP)
         0:       exp_y = a_q & b_q;
         1:       exp_y = a_q | b_q;
         2:       exp_y = a_q ^ b_q;
         3:       exp_y = ~(a_q & b_q);
         4:       exp_y = ~(a_q | b_q);
         5:       exp_y = ~(a_q ^ b_q);
         default: exp_y = 1'b0;
      endcase
   end

   assign mismatch = (bus.y != exp_y);

   // Next-state and next-output logic; start takes priority over any compare.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      settle_d  = settle_q;
      vec_cnt_d = vec_cnt_q;
      err_cnt_d = err_cnt_q;
      ff_d      = ff_q;
      ffv_d     = ffv_q;
      overrun_d = overrun_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;

      if (bus.start) begin
         state_d   = ARMED;
         vec_cnt_d = '0;
         err_cnt_d = '0;
         ff_d      = '0;
         ffv_d     = 1'b0;
         overrun_d = 1'b0;
         busy_d    = 1'b1;
         done_d    = 1'b0;
         pass_d    = 1'b0;
      end else begin
         case (state_q)
            ARMED: begin
               if (bus.vec_valid) begin
                  a_d      = bus.a;
                  b_d      = bus.b;
                  settle_d = SETTLE_LOAD;
                  state_d  = SETTLE_WAIT;
               end
            end
            SETTLE_WAIT: begin
               // A new vector while one is still settling is dropped and flagged.
               if (bus.vec_valid) overrun_d = 1'b1;
               if (settle_q != '0) begin
                  settle_d = settle_q - SET_W'(1);
               end else begin
                  vec_cnt_d = vec_cnt_q + CNT_W'(1);
                  state_d   = ARMED;
                  if (mismatch) begin
                     if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                     if (!ffv_q) begin
                        ff_d  = {a_q, b_q, bus.y};
                        ffv_d = 1'b1;
                     end
                  end
                  if ((vec_cnt_d == VEC_LAST) || (STOP_ON_FAIL && mismatch)) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_cnt_d == '0);
                  end
               end
            end
            // IDLE and DONE only leave on start; vec_valid is ignored there.
            IDLE, DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         settle_q  <= '0;
         vec_cnt_q <= '0;
         err_cnt_q <= '0;
         ff_q      <= '0;
         ffv_q     <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         settle_q  <= settle_d;
         vec_cnt_q <= vec_cnt_d;
         err_cnt_q <= err_cnt_d;
         ff_q      <= ff_d;
         ffv_q     <= ffv_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.vec_cnt        = vec_cnt_q;
   assign bus.err_cnt        = err_cnt_q;
   assign bus.first_fail     = ff_q;
   assign bus.first_fail_vld = ffv_q;
   assign bus.overrun        = overrun_q;

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Self-checking response monitor for the 2-input gate DUTs in the Gate library. It is the receive/check end of the stimulus benches.
- Latches each applied (a,b) vector and waits a settle time. It then samples the DUT output y and compares it against the expected truth-table value for the selected gate op.
- Counts vectors and errors, and reports pass/fail when the run completes.
- Sits beside the DUT in a bench; the stimulus driver pulses vec_valid once per applied vector.

Parameters:
- GATE_OP, 2, expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; any other value gives expected = 0.
- NUM_VECTORS, 4, vectors per run (≥1).
- SETTLE, 1, clk cycles between vector latch and y sample (≥1).
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run and clears counters/flags.
- vec_valid  in  1  one-cycle pulse; a,b are valid and applied to the DUT this cycle.
- a  in  1  DUT input a as driven.
- b  in  1  DUT input b as driven.
- y  in  1  DUT output.
- busy  out  1  run in progress.
- done  out  1  run finished; held high until the next start or rst.
- pass  out  1  valid when done: err_cnt == 0.
- vec_cnt  out  CNT_W  vectors checked this run.
- err_cnt  out  CNT_W  mismatches this run; saturates at all-ones.
- first_fail  out  3  {a,b,y} of the first mismatch.
- first_fail_vld  out  1  first_fail holds a captured value.
- overrun  out  1  sticky: vec_valid arrived while a check was pending.

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, pass, vec_cnt, err_cnt, first_fail, first_fail_vld, overrun.
- FSM states: IDLE, ARMED, SETTLE_WAIT, DONE.
- IDLE: wait for start.
  - start → clear vec_cnt, err_cnt, first_fail, first_fail_vld, overrun, done, pass; go to ARMED; busy=1.
- ARMED: on vec_valid, latch a,b into a_q,b_q; load the settle counter with SETTLE-1; go to SETTLE_WAIT.
- SETTLE_WAIT:
  - Counter ≠ 0: decrement.
  - Counter == 0 (SETTLE clk edges after the vec_valid edge):
    - Sample y and compute exp = f(a_q,b_q).
    - vec_cnt += 1.
    - If y ≠ exp: err_cnt += 1 (saturating). If first_fail_vld is 0, set first_fail = {a_q,b_q,y} and first_fail_vld = 1.
    - If the new vec_cnt == NUM_VECTORS → DONE, else → ARMED.
  - vec_valid seen in SETTLE_WAIT: vector ignored; overrun = 1 (sticky until start/rst).
- DONE: busy=0, done=1, pass = (err_cnt==0). vec_valid is ignored (no overrun). start restarts the run exactly as from IDLE.
- Counters, error update and state change all take effect on the same edge as the compare.
- start while busy: abort the current run; clear as in IDLE; → ARMED. start wins over a simultaneous compare.
- rst in any state: return to the reset values on the next edge; it overrides start and vec_valid.
- Expected-value logic is combinational on a_q,b_q. All outputs are registered.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_FAIL_EN.
- When defined: the first mismatch moves the FSM to DONE on the compare edge, regardless of vec_cnt, with pass=0. err_cnt is therefore at most 1.
- When undefined: the run always completes NUM_VECTORS vectors, and all mismatches are counted.

Test Plan (GATE_OP=2, NUM_VECTORS=4, SETTLE=1 unless noted):
- rst=1 for 2 cycles, then 0 → all outputs 0; vec_valid pulses are ignored until start.
- start; apply (0,0),(0,1),(1,0),(1,1) with correct XOR y, one vec_valid per 2 cycles → done=1, pass=1, vec_cnt=4, err_cnt=0, first_fail_vld=0.
- Same sequence with y forced 0 on (1,0) and on (1,1) → done=1, pass=0, err_cnt=1, first_fail=3'b100, first_fail_vld=1.
- SETTLE=3: vec_valid on cycle n, y changes at n+2 → sample at n+3 uses the new y. A second vec_valid at n+1 sets overrun=1, and vec_cnt still advances only once.
- start mid-run after 2 vectors → vec_cnt=0, err_cnt=0, busy=1. Then 4 good vectors → pass=1.
- GATE_CHK_STOP_ON_FAIL_EN defined, bad y on vector 2 → done=1 on that compare edge, vec_cnt=2, err_cnt=1, pass=0.
